block_map_wr_arbiter: RTL and testbench



---
 rtl/block_map_wr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_block_map_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_map_wr_arbiter.sv
// rtl/block_map_wr_arbiter.sv - block map RAM write-port arbiter with full-map clear sweep.
// Define BMW_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module block_map_wr_arbiter #(
   parameter int                N_REQ     = 4,
   parameter int                ADDR_W    = 10,
   parameter int                DATA_W    = 1,
   parameter int                MAP_DEPTH = 891,
   parameter logic [DATA_W-1:0] CLR_DATA  = '0
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*ADDR_W-1:0]   addr_in_i,
   input  logic [N_REQ*DATA_W-1:0]   data_in_i,
   input  logic                      clear_start_i,
   input  logic                      gameover_i,
   output logic [ADDR_W-1:0]         block_w_addr_o,
   output logic [DATA_W-1:0]         block_w_data_o,
   output logic                      block_we_o,
   output logic [N_REQ-1:0]          ack_o,
   output logic                      err_o,
   output logic                      clear_busy_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAP_DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_WIDE = (ADDR_W + 1)'(MAP_DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;

   logic [N_REQ-1:0]    eligible;
   logic                found;
   logic [N_REQ-1:0]    win_onehot;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;
   logic                in_range;

`ifndef BMW_FIXED_PRIO_EN
   localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   logic [RR_W-1:0]     rr_q, rr_d;
   logic [RR_W-1:0]     win_idx;
   int                  cand;
`endif

   // A requester whose ack is currently showing must not be granted again this cycle.
   assign eligible = req_i & ~ack_q & {N_REQ{~gameover_i}};

`ifdef BMW_FIXED_PRIO_EN
   always_comb begin
      found      = 1'b0;
      win_onehot = '0;
      win_addr   = '0;
      win_data   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            found         = 1'b1;
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
            win_addr      = addr_in_i[i*ADDR_W +: ADDR_W];
            win_data      = data_in_i[i*DATA_W +: DATA_W];
         end
      end
   end
`else
   always_comb begin
      found      = 1'b0;
      win_onehot = '0;
      win_addr   = '0;
      win_data   = '0;
      win_idx    = '0;
      cand       = 0;
      // Search starts just above the last winner and wraps.
      for (int k = 1; k <= N_REQ; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!found && eligible[cand]) begin
            found            = 1'b1;
            win_onehot[cand] = 1'b1;
            win_addr         = addr_in_i[cand*ADDR_W +: ADDR_W];
            win_data         = data_in_i[cand*DATA_W +: DATA_W];
            win_idx          = RR_W'(cand);
         end
      end
   end
`endif

   assign in_range = ({1'b0, win_addr} < DEPTH_WIDE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      ack_d   = '0;
      err_d   = 1'b0;
      busy_d  = 1'b0;
`ifndef BMW_FIXED_PRIO_EN
      rr_d    = rr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (clear_start_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               we_d    = 1'b1;
               addr_d  = '0;
               data_d  = CLR_DATA;
               busy_d  = 1'b1;
            end else if (found) begin
               ack_d  = win_onehot;
               addr_d = win_addr;
               data_d = win_data;
               we_d   = in_range;
               err_d  = ~in_range;
`ifndef BMW_FIXED_PRIO_EN
               rr_d   = win_idx;
`endif
            end
         end
         ST_CLEAR: begin
            // cnt_q is the address currently on the write port.
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d  = cnt_q + ADDR_W'(1);
               we_d   = 1'b1;
               addr_d = cnt_q + ADDR_W'(1);
               data_d = CLR_DATA;
               busy_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifndef BMW_FIXED_PRIO_EN
         rr_q    <= RR_W'(N_REQ - 1);
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
`ifndef BMW_FIXED_PRIO_EN
         rr_q    <= rr_d;
`endif
      end
   end

   assign block_w_addr_o = addr_q;
   assign block_w_data_o = data_q;
   assign block_we_o     = we_q;
   assign ack_o          = ack_q;
   assign err_o          = err_q;
   assign clear_busy_o   = busy_q;

endmodule

// File: tb/tb_block_map_wr_arbiter.sv
// tb/tb_block_map_wr_arbiter.sv - self-checking bench for block_map_wr_arbiter.
module tb_block_map_wr_arbiter;

   localparam int N     = 4;
   localparam int AW    = 10;
   localparam int DEPTH = 891;

   logic          clk = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N-1:0]  data = '0;
   logic          clr = 1'b0;
   logic          go = 1'b0;
   logic          rst = 1'b1;

   logic [AW-1:0] w_addr;
   logic          w_data;
   logic          we;
   logic [N-1:0]  ack;
   logic          err;
   logic          busy;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: sweep position (-1 = idle), last winner, last ack.
   int            m_pos = -1;
   int            m_rr  = N - 1;
   logic [N-1:0]  m_ack = '0;

   logic          e_we, e_data, e_err, e_busy;
   logic [AW-1:0] e_addr;
   logic [N-1:0]  e_ack;

   typedef struct {
      logic [N-1:0]    req;
      logic [N*AW-1:0] addr;
      logic [N-1:0]    data;
      logic            go;
      logic            rst;
      logic            we;
      logic [AW-1:0]   waddr;
      logic            wdata;
      logic [N-1:0]    ack;
      logic            err;
   } vec_t;

   vec_t tbl[$];

   block_map_wr_arbiter dut (
      .clk_i          (clk),
      .reset_i        (rst),
      .req_i          (req),
      .addr_in_i      (addr),
      .data_in_i      (data),
      .clear_start_i  (clr),
      .gameover_i     (go),
      .block_w_addr_o (w_addr),
      .block_w_data_o (w_data),
      .block_we_o     (we),
      .ack_o          (ack),
      .err_o          (err),
      .clear_busy_o   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model();
      logic [N-1:0] elig;
      int           c;
      bit           hit;
      e_we = 0; e_addr = '0; e_data = 0; e_ack = '0; e_err = 0; e_busy = 0;
      hit = 0;
      if (rst) begin
         m_pos = -1;
         m_rr  = N - 1;
      end else if (m_pos >= 0) begin
         if (m_pos == DEPTH - 1) begin
            m_pos = -1;
         end else begin
            m_pos++;
            e_we = 1; e_addr = AW'(m_pos); e_busy = 1;
         end
      end else if (clr) begin
         m_pos = 0;
         e_we = 1; e_busy = 1;
      end else begin
         elig = go ? '0 : (req & ~m_ack);
         for (int k = 1; k <= N; k++) begin
`ifdef BMW_FIXED_PRIO_EN
            c = k - 1;
`else
            c = (m_rr + k) % N;
`endif
            if (!hit && elig[c]) begin
               hit      = 1;
               m_rr     = c;
               e_ack[c] = 1'b1;
               e_addr   = addr[c*AW +: AW];
               e_data   = data[c];
               e_we     = (int'(e_addr) < DEPTH);
               e_err    = !e_we;
            end
         end
      end
      m_ack = e_ack;
   endtask

   task automatic step();
      model();
      @(posedge clk);
      #1;
      check("outputs", {58'd0, we, ack, err, busy}, {58'd0, e_we, e_ack, e_err, e_busy});
      if (e_we) check("write_word", {53'd0, w_addr, w_data}, {53'd0, e_addr, e_data});
   endtask

   task automatic add_row(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic [N-1:0] d,
                          input logic g, input logic rs, input logic ew, input logic [AW-1:0] ea,
                          input logic ed, input logic [N-1:0] ek, input logic ee);
      vec_t v;
      v.req = r; v.addr = a; v.data = d; v.go = g; v.rst = rs;
      v.we = ew; v.waddr = ea; v.wdata = ed; v.ack = ek; v.err = ee;
      tbl.push_back(v);
   endtask

   initial begin
      int  busy_cnt;
      int  next_addr;
      bit  seq_ok;
      bit  fell;
      bit  found400;
      bit  bad;

      //       req      addr {a3,a2,a1,a0}                    data     go rst  we addr  d  ack      err
      add_row(4'b0000, '0,                                    4'b0000, 0, 1,  0, 0,    0, 4'b0000, 0);
      add_row(4'b0001, {10'd0, 10'd0, 10'd0, 10'd35},        4'b0000, 0, 0,  1, 35,   0, 4'b0001, 0);
      add_row(4'b0000, {10'd0, 10'd0, 10'd0, 10'd35},        4'b0000, 0, 0,  0, 0,    0, 4'b0000, 0);
      add_row(4'b0000, '0,                                    4'b0000, 0, 1,  0, 0,    0, 4'b0000, 0);
      add_row(4'b1111, {10'd40, 10'd30, 10'd20, 10'd10},     4'b1010, 0, 0,  1, 10,   0, 4'b0001, 0);
      add_row(4'b1110, {10'd40, 10'd30, 10'd20, 10'd10},     4'b1010, 0, 0,  1, 20,   1, 4'b0010, 0);
      add_row(4'b1100, {10'd40, 10'd30, 10'd20, 10'd10},     4'b1010, 0, 0,  1, 30,   0, 4'b0100, 0);
      add_row(4'b1000, {10'd40, 10'd30, 10'd20, 10'd10},     4'b1010, 0, 0,  1, 40,   1, 4'b1000, 0);
      add_row(4'b0000, '0,                                    4'b0000, 0, 0,  0, 0,    0, 4'b0000, 0);
      add_row(4'b0001, {10'd0, 10'd0, 10'd0, 10'd900},       4'b0000, 0, 0,  0, 0,    0, 4'b0001, 1);
      add_row(4'b0000, '0,                                    4'b0000, 0, 0,  0, 0,    0, 4'b0000, 0);
      add_row(4'b0010, {10'd0, 10'd0, 10'd5, 10'd0},         4'b0010, 1, 0,  0, 0,    0, 4'b0000, 0);
      add_row(4'b0010, {10'd0, 10'd0, 10'd5, 10'd0},         4'b0010, 1, 0,  0, 0,    0, 4'b0000, 0);
      add_row(4'b0010, {10'd0, 10'd0, 10'd5, 10'd0},         4'b0010, 0, 0,  1, 5,    1, 4'b0010, 0);
      add_row(4'b0011, {10'd0, 10'd0, 10'd5, 10'd7},         4'b0010, 0, 0,  1, 7,    0, 4'b0001, 0);
      add_row(4'b0010, {10'd0, 10'd0, 10'd5, 10'd7},         4'b0010, 0, 0,  1, 5,    1, 4'b0010, 0);
      add_row(4'b0000, '0,                                    4'b0000, 0, 0,  0, 0,    0, 4'b0000, 0);

      foreach (tbl[i]) begin
         req = tbl[i].req; addr = tbl[i].addr; data = tbl[i].data;
         go = tbl[i].go; rst = tbl[i].rst; clr = 1'b0;
         step();
         check($sformatf("tbl%0d_ctl", i), {58'd0, we, ack, err, busy},
               {58'd0, tbl[i].we, tbl[i].ack, tbl[i].err, 1'b0});
         if (tbl[i].we)
            check($sformatf("tbl%0d_word", i), {53'd0, w_addr, w_data}, {53'd0, tbl[i].waddr, tbl[i].wdata});
         if (tbl[i].rst)
            check($sformatf("tbl%0d_rstword", i), {53'd0, w_addr, w_data}, 64'd0);
      end
      rst = 1'b0;

      // Clear sweep with a pending request, redundant clear_start and gameover mid-sweep.
      req = 4'b0010; addr = {10'd0, 10'd0, 10'd123, 10'd0}; data = 4'b0010;
      clr = 1'b1;
      busy_cnt = 0; next_addr = 0; seq_ok = 1; fell = 0; bad = 0;
      for (int k = 0; k < 1000 && !fell; k++) begin
         step();
         clr = (k == 100);
         go  = (k >= 200 && k < 210);
         if (busy) begin
            if (!we || int'(w_addr) != next_addr || w_data !== 1'b0 || ack != 0) seq_ok = 0;
            next_addr++;
            busy_cnt++;
         end else begin
            fell = 1;
            bad  = (we || ack != 0);
         end
      end
      check("sweep_len", 64'(busy_cnt), 64'(DEPTH));
      check("sweep_seq", 64'(seq_ok), 64'd1);
      check("sweep_fell", 64'(fell), 64'd1);
      check("sweep_end_quiet", 64'(bad), 64'd0);
      step();
      check("post_sweep_ack", {59'd0, ack, we}, {59'd0, 4'b0010, 1'b1});
      check("post_sweep_addr", 64'(w_addr), 64'd123);
      req = '0;
      step();

      // Reset while the sweep is at address 400.
      clr = 1'b1;
      found400 = 0;
      for (int k = 0; k < 1000 && !found400; k++) begin
         step();
         clr = 1'b0;
         if (busy && w_addr == 10'd400) found400 = 1;
      end
      check("reached_400", 64'(found400), 64'd1);
      rst = 1'b1;
      step();
      check("reset_mid_sweep", {58'd0, we, busy, ack}, 64'd0);
      rst = 1'b0;
      step();
      check("after_reset_idle", {58'd0, we, busy, ack}, 64'd0);

      // Gameover holds off grants for 10 cycles.
      go = 1'b1; req = 4'b0001; addr = {10'd0, 10'd0, 10'd0, 10'd77}; data = 4'b0001;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (we || ack != 0) bad = 1;
      end
      check("gameover_block", 64'(bad), 64'd0);
      go = 1'b0;
      step();
      check("gameover_release", {58'd0, we, ack, err}, {58'd0, 1'b1, 4'b0001, 1'b0});
      req = '0;
      step();

      // Random requesters against the reference model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (req[i] && e_ack[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else begin
                  addr[i*AW +: AW] = AW'($urandom_range(0, 950));
                  data[i] = 1'($urandom_range(0, 1));
               end
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               addr[i*AW +: AW] = AW'($urandom_range(0, 950));
               data[i] = 1'($urandom_range(0, 1));
            end
         end
         clr = ($urandom_range(0, 599) == 0);
         go  = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
